instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ACK_TIMEOUT, default 16: maximum FETCH cycles allowed without imem_ack; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ctrl_in_address  in  32  next PC from the control logic, sampled only on an accepted retire.
REQ-006 next_pc_valid  in  1  core has finished the current instruction and ctrl_in_address is valid.
REQ-007 halt  in  1  stop fetching after the retiring instruction.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  read address, equal to pc.
REQ-010 imem_ack  in  1  imem_rdata valid this cycle.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 instrn  out  32  registered instruction word.
REQ-013 instrn_opcode  out  6  equal to instrn[31:26].
REQ-014 instrn_valid  out  1  instrn held for execution.
REQ-015 pc  out  32  current program counter.
REQ-016 address_plus_4  out  32  pc + 4, modulo 2^32.
REQ-017 branch_address  out  32  address_plus_4 + {sign-extended instrn[15:0], 2'b00}, modulo 2^32.
REQ-018 retire_count  out  32  count of accepted retires.
REQ-019 misaligned_err, timeout_err, halted  out  1 each  sticky status flags.

Function
REQ-020 The FSM SHALL have exactly four states: FETCH, ISSUE, HALTED and ERROR.
REQ-021 In FETCH, imem_req SHALL be 1; in every other state it SHALL be 0.
REQ-022 imem_addr, address_plus_4, branch_address and instrn_opcode SHALL be combinational from pc and instrn.
REQ-023 FETCH with imem_ack=1 in cycle N SHALL load instrn <= imem_rdata and enter ISSUE, so that instrn_valid=1 and imem_req=0 from cycle N+1.
REQ-024 ISSUE with next_pc_valid=1 in cycle M SHALL count as an accepted retire:
- retire_count increments by 1 and wraps from 32'hFFFF_FFFF to 0.
- instrn_valid=0 from cycle M+1.
REQ-025 On an accepted retire with halt=0 and ctrl_in_address[1:0]=2'b00:
- pc <= ctrl_in_address.
- The state becomes FETCH, so imem_req=1 in cycle M+1.
REQ-026 On an accepted retire with halt=0 and ctrl_in_address[1:0]!=2'b00:
- pc <= ctrl_in_address.
- misaligned_err <= 1 and the state becomes ERROR.
REQ-027 On an accepted retire with halt=1, halt SHALL take priority over misalignment:
- pc is unchanged.
- halted <= 1 and the state becomes HALTED.
REQ-028 An ack timer SHALL behave as follows:
- It clears on every entry to FETCH.
- It increments on each FETCH cycle without imem_ack.
- A FETCH cycle with timer = ACK_TIMEOUT-1 and imem_ack=0 sets timeout_err <= 1 and enters ERROR.
- imem_ack in that same cycle wins and takes the normal path.
REQ-029 imem_ack SHALL be ignored outside FETCH; next_pc_valid and halt SHALL be ignored outside ISSUE.
REQ-030 In ISSUE, instrn and pc SHALL hold stable until the retire is accepted.
REQ-031 HALTED and ERROR SHALL be exited only by rst; in those states instrn_valid=0 and imem_req=0.

Reset
REQ-032 rst=1 at a clock edge SHALL apply the following in any state, including mid-handshake:
- pc <= RESET_PC and instrn <= 0.
- instrn_valid, retire_count and all flags <= 0.
- Ack timer <= 0 and state <= FETCH.
REQ-033 During the rst=1 cycle, outputs SHALL be computed from the reset values already loaded; imem_req=1 from the first cycle after rst deasserts.
REQ-034 An imem_ack arriving in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-035 Reset, then ack one cycle later with rdata 32'h8C22_0004 -> instrn_valid=1; instrn_opcode=6'h23; address_plus_4=32'h4; branch_address=32'h14.
REQ-036 ISSUE, then retire with ctrl_in_address=32'h0000_0040 -> pc=32'h40; imem_addr=32'h40; imem_req=1 the next cycle; retire_count=1.
REQ-037 Instruction 32'h1000_FFFF at pc 32'h0000_0010 -> branch_address=32'h0000_0010 (negative offset).
REQ-038 Retire with ctrl_in_address=32'h0000_0042 -> misaligned_err=1; state ERROR; imem_req stays 0 until rst.
REQ-039 ACK_TIMEOUT=16 with no ack -> imem_req high for exactly 16 cycles, then timeout_err=1; an ack in the 16th cycle instead gives a normal ISSUE.
REQ-040 Retire with halt=1 and misaligned address -> halted=1, misaligned_err=0, pc unchanged; a later rst=1 mid-FETCH restores all REQ-032 values.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Purpose
//   Instruction-memory read bus between the fetch unit and an instruction
//   memory. The fetch unit holds imem_req high while it waits for a word.
//   The memory answers with a single-cycle imem_ack and puts the word on
//   imem_rdata in that same cycle.
//
// Signals
//   imem_req    fetch unit -> memory   read request (level, held while waiting)
//   imem_addr   fetch unit -> memory   32-bit word-aligned read address
//   imem_ack    memory -> fetch unit   imem_rdata is valid this cycle
//   imem_rdata  memory -> fetch unit   32-bit instruction word
//
// Modports
//   master  used by the fetch unit
//   slave   used by the memory model
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose
//   Single-outstanding instruction fetcher with a four-state control FSM.
//   FETCH    request the word at pc and wait for imem_ack. An ack timer
//            bounds the wait.
//   ISSUE    hold the fetched word for the core until it retires the word
//            with next_pc_valid.
//   HALTED   entered on a retire with halt=1. Left only through rst.
//   ERROR    entered when the retire target is misaligned or the ack times
//            out. Left only through rst.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   ACK_TIMEOUT  maximum FETCH cycles without imem_ack, legal range 1..255
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous, active-high reset
//   imem             instruction-memory bus (master side)
//   ctrl_in_address  next PC from control logic, sampled on an accepted retire
//   next_pc_valid    core has finished the instruction; ctrl_in_address is valid
//   halt             stop fetching after the retiring instruction
//   instrn           registered instruction word
//   instrn_opcode    instrn[31:26]
//   instrn_valid     instrn is held for execution (state ISSUE)
//   pc               current program counter
//   address_plus_4   pc + 4
//   branch_address   pc + 4 + (sign-extended instrn[15:0] << 2)
//   retire_count     number of accepted retires (wraps)
//   misaligned_err   sticky: retire target had nonzero address bits [1:0]
//   timeout_err      sticky: no imem_ack within ACK_TIMEOUT FETCH cycles
//   halted           sticky: fetching stopped by halt
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,

  instr_fetch_unit_if.master        imem,

  input  logic [31:0]               ctrl_in_address,
  input  logic                      next_pc_valid,
  input  logic                      halt,

  output logic [31:0]               instrn,
  output logic [5:0]                instrn_opcode,
  output logic                      instrn_valid,
  output logic [31:0]               pc,
  output logic [31:0]               address_plus_4,
  output logic [31:0]               branch_address,
  output logic [31:0]               retire_count,
  output logic                      misaligned_err,
  output logic                      timeout_err,
  output logic                      halted
);

  // -------------------------------------------------------------------------
  // Parameter sanity: the ack timer is 8 bits wide.
  // -------------------------------------------------------------------------
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
    $error("instr_fetch_unit: ACK_TIMEOUT must be in 1..255");
  end

  // The final FETCH cycle in which an ack is still accepted.
  localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e      state_q,        state_d;
  logic [31:0] pc_q,           pc_d;
  logic [31:0] instrn_q,       instrn_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic [7:0]  timer_q,        timer_d;
  logic        misaligned_q,   misaligned_d;
  logic        timeout_q,      timeout_d;
  logic        halted_q,       halted_d;

  // NOTE: use non-blocking assignments for every register. All registers
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Any imem_ack in this cycle is dropped because the reset branch
      // never looks at the bus.
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      instrn_q       <= '0;
      retire_count_q <= '0;
      timer_q        <= '0;
      misaligned_q   <= 1'b0;
      timeout_q      <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instrn_q       <= instrn_d;
      retire_count_q <= retire_count_d;
      timer_q        <= timer_d;
      misaligned_q   <= misaligned_d;
      timeout_q      <= timeout_d;
      halted_q       <= halted_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default before the case
  // statement. Any path that does not assign it therefore infers no latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instrn_d       = instrn_q;
    retire_count_d = retire_count_q;
    timer_d        = timer_q;
    misaligned_d   = misaligned_q;
    timeout_d      = timeout_q;
    halted_d       = halted_q;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          // An ack in the last allowed cycle still wins over the timeout.
          instrn_d = imem.imem_rdata;
          state_d  = ISSUE;
          timer_d  = '0;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = ERROR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      ISSUE: begin
        // pc and instrn keep their values until the core accepts the retire.
        if (next_pc_valid) begin
          retire_count_d = retire_count_q + 32'd1;
          if (halt) begin
            // halt wins over a misaligned target, and pc is left unchanged.
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d = ctrl_in_address;
            if (ctrl_in_address[1:0] != 2'b00) begin
              misaligned_d = 1'b1;
              state_d      = ERROR;
            end else begin
              // The ack timer starts from zero each time FETCH is entered.
              timer_d = '0;
              state_d = FETCH;
            end
          end
        end
      end

      // Terminal states: only rst leaves them.
      HALTED: state_d = HALTED;
      ERROR:  state_d = ERROR;

      default: state_d = ERROR;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: all come from registered state, so in the rst cycle they
  // already show the reset values.
  // -------------------------------------------------------------------------
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  assign pc             = pc_q;
  assign instrn         = instrn_q;
  assign instrn_opcode  = instrn_q[31:26];
  assign instrn_valid   = (state_q == ISSUE);
  assign address_plus_4 = pc_q + 32'd4;
  // The word offset is sign-extended and scaled to bytes.
  assign branch_address = address_plus_4 + {{14{instrn_q[15]}}, instrn_q[15:0], 2'b00};
  assign retire_count   = retire_count_q;
  assign misaligned_err = misaligned_q;
  assign timeout_err    = timeout_q;
  assign halted         = halted_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed testbench for instr_fetch_unit. The bench drives inputs 1 ns
// after each rising edge and samples outputs at that same point. The
// design is built with RESET_PC = 0 and ACK_TIMEOUT = 16.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_in_address;
  logic        next_pc_valid;
  logic        halt;
  logic [31:0] instrn;
  logic [5:0]  instrn_opcode;
  logic        instrn_valid;
  logic [31:0] pc;
  logic [31:0] address_plus_4;
  logic [31:0] branch_address;
  logic [31:0] retire_count;
  logic        misaligned_err;
  logic        timeout_err;
  logic        halted;

  int passed;
  int total;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem            (bus),
    .ctrl_in_address (ctrl_in_address),
    .next_pc_valid   (next_pc_valid),
    .halt            (halt),
    .instrn          (instrn),
    .instrn_opcode   (instrn_opcode),
    .instrn_valid    (instrn_valid),
    .pc              (pc),
    .address_plus_4  (address_plus_4),
    .branch_address  (branch_address),
    .retire_count    (retire_count),
    .misaligned_err  (misaligned_err),
    .timeout_err     (timeout_err),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset for one edge, then release it with all inputs idle.
  task automatic do_reset();
    rst = 1'b1; bus.imem_ack = 1'b0; next_pc_valid = 1'b0; halt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Count the cycles imem_req stays high, up to a bound of 40.
  task automatic count_req(output int n);
    n = 0;
    while (bus.imem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    ctrl_in_address = '0; next_pc_valid = 1'b0; halt = 1'b0;
    tick();
    // This ack arrives together with rst and must be discarded.
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    total++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); else passed++;
    total++; if (instrn !== 32'h0) $display("FAIL reset_instrn got=%h exp=%h", instrn, 32'h0); else passed++;
    total++; if (instrn_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instrn_valid); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL reset_req got=%b exp=1", bus.imem_req); else passed++;
    total++; if (retire_count !== 32'h0) $display("FAIL reset_count got=%h exp=0", retire_count); else passed++;
    total++; if ({misaligned_err, timeout_err, halted} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {misaligned_err, timeout_err, halted}); else passed++;
    rst = 1'b0; bus.imem_ack = 1'b0;
  endtask

  task automatic test_fetch_issue();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C22_0004;
    tick();
    bus.imem_ack = 1'b0;
    total++; if (instrn_valid !== 1'b1) $display("FAIL fetch_valid got=%b exp=1", instrn_valid); else passed++;
    total++; if (bus.imem_req !== 1'b0) $display("FAIL fetch_req_low got=%b exp=0", bus.imem_req); else passed++;
    total++; if (instrn !== 32'h8C22_0004) $display("FAIL fetch_instrn got=%h exp=8c220004", instrn); else passed++;
    total++; if (instrn_opcode !== 6'h23) $display("FAIL fetch_opcode got=%h exp=23", instrn_opcode); else passed++;
    total++; if (address_plus_4 !== 32'h4) $display("FAIL fetch_ap4 got=%h exp=4", address_plus_4); else passed++;
    total++; if (branch_address !== 32'h14) $display("FAIL fetch_branch got=%h exp=14", branch_address); else passed++;
    // In ISSUE an ack is ignored, and instrn and pc stay stable.
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
    tick(); tick();
    bus.imem_ack = 1'b0;
    total++; if (instrn !== 32'h8C22_0004) $display("FAIL issue_hold_instrn got=%h exp=8c220004", instrn); else passed++;
    total++; if (instrn_valid !== 1'b1) $display("FAIL issue_hold_valid got=%b exp=1", instrn_valid); else passed++;
  endtask

  task automatic test_retire();
    ctrl_in_address = 32'h0000_0040; next_pc_valid = 1'b1;
    tick();
    next_pc_valid = 1'b0;
    total++; if (pc !== 32'h40) $display("FAIL retire_pc got=%h exp=40", pc); else passed++;
    total++; if (bus.imem_addr !== 32'h40) $display("FAIL retire_addr got=%h exp=40", bus.imem_addr); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL retire_req got=%b exp=1", bus.imem_req); else passed++;
    total++; if (retire_count !== 32'd1) $display("FAIL retire_count got=%0d exp=1", retire_count); else passed++;
    total++; if (instrn_valid !== 1'b0) $display("FAIL retire_valid got=%b exp=0", instrn_valid); else passed++;
  endtask

  task automatic test_branch_negative();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0000;
    tick();
    bus.imem_ack = 1'b0; ctrl_in_address = 32'h0000_0010; next_pc_valid = 1'b1;
    tick();
    next_pc_valid = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1000_FFFF;
    tick();
    bus.imem_ack = 1'b0;
    total++; if (pc !== 32'h10) $display("FAIL neg_pc got=%h exp=10", pc); else passed++;
    total++; if (address_plus_4 !== 32'h14) $display("FAIL neg_ap4 got=%h exp=14", address_plus_4); else passed++;
    total++; if (branch_address !== 32'h10) $display("FAIL neg_branch got=%h exp=10", branch_address); else passed++;
    total++; if (instrn_opcode !== 6'h04) $display("FAIL neg_opcode got=%h exp=04", instrn_opcode); else passed++;
    total++; if (retire_count !== 32'd2) $display("FAIL neg_count got=%0d exp=2", retire_count); else passed++;
  endtask

  task automatic test_misaligned();
    ctrl_in_address = 32'h0000_0042; next_pc_valid = 1'b1; halt = 1'b0;
    tick();
    total++; if (misaligned_err !== 1'b1) $display("FAIL mis_flag got=%b exp=1", misaligned_err); else passed++;
    total++; if (pc !== 32'h42) $display("FAIL mis_pc got=%h exp=42", pc); else passed++;
    total++; if (retire_count !== 32'd3) $display("FAIL mis_count got=%0d exp=3", retire_count); else passed++;
    // ERROR is terminal: acks and retires are ignored there.
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.imem_req !== 1'b0) $display("FAIL mis_req_low cycle=%0d got=%b exp=0", i, bus.imem_req); else passed++;
    end
    total++; if (retire_count !== 32'd3) $display("FAIL mis_count_frozen got=%0d exp=3", retire_count); else passed++;
    total++; if (instrn_valid !== 1'b0) $display("FAIL mis_valid got=%b exp=0", instrn_valid); else passed++;
    bus.imem_ack = 1'b0; next_pc_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    count_req(n);
    total++; if (n !== 16) $display("FAIL timeout_req_cycles got=%0d exp=16", n); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL timeout_flag got=%b exp=1", timeout_err); else passed++;
    total++; if (misaligned_err !== 1'b0) $display("FAIL timeout_mis got=%b exp=0", misaligned_err); else passed++;
    tick();
    total++; if (bus.imem_req !== 1'b0) $display("FAIL timeout_req_low got=%b exp=0", bus.imem_req); else passed++;
  endtask

  task automatic test_ack_last_cycle();
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    total++; if (bus.imem_req !== 1'b1) $display("FAIL last_req_still got=%b exp=1", bus.imem_req); else passed++;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hA5A5_0001;
    tick();
    bus.imem_ack = 1'b0;
    total++; if (instrn_valid !== 1'b1) $display("FAIL last_valid got=%b exp=1", instrn_valid); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL last_timeout got=%b exp=0", timeout_err); else passed++;
    total++; if (instrn !== 32'hA5A5_0001) $display("FAIL last_instrn got=%h exp=a5a50001", instrn); else passed++;
  endtask

  // Continues from ISSUE with pc = 0, left by test_ack_last_cycle.
  task automatic test_halt_priority();
    ctrl_in_address = 32'h0000_0042; next_pc_valid = 1'b1; halt = 1'b1;
    tick();
    next_pc_valid = 1'b0; halt = 1'b0;
    total++; if (halted !== 1'b1) $display("FAIL halt_flag got=%b exp=1", halted); else passed++;
    total++; if (misaligned_err !== 1'b0) $display("FAIL halt_mis got=%b exp=0", misaligned_err); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL halt_pc got=%h exp=0", pc); else passed++;
    total++; if (retire_count !== 32'd1) $display("FAIL halt_count got=%0d exp=1", retire_count); else passed++;
    bus.imem_ack = 1'b1;
    tick(); tick();
    bus.imem_ack = 1'b0;
    total++; if ({bus.imem_req, instrn_valid} !== 2'b00)
      $display("FAIL halt_idle got=%b exp=00", {bus.imem_req, instrn_valid}); else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    do_reset();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C22_0004;
    tick();
    bus.imem_ack = 1'b0; ctrl_in_address = 32'h0000_0080; next_pc_valid = 1'b1;
    tick();
    next_pc_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (pc !== 32'h80) $display("FAIL mid_pre_pc got=%h exp=80", pc); else passed++;
    rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    tick();
    total++; if (pc !== 32'h0) $display("FAIL mid_pc got=%h exp=0", pc); else passed++;
    total++; if (instrn !== 32'h0) $display("FAIL mid_instrn got=%h exp=0", instrn); else passed++;
    total++; if (retire_count !== 32'h0) $display("FAIL mid_count got=%h exp=0", retire_count); else passed++;
    total++; if ({instrn_valid, misaligned_err, timeout_err, halted} !== 4'b0000)
      $display("FAIL mid_flags got=%b exp=0000", {instrn_valid, misaligned_err, timeout_err, halted}); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL mid_req got=%b exp=1", bus.imem_req); else passed++;
    rst = 1'b0; bus.imem_ack = 1'b0;
    // The ack timer must also restart from zero.
    count_req(n);
    total++; if (n !== 16) $display("FAIL mid_timer_cycles got=%0d exp=16", n); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_fetch_issue();
    test_retire();
    test_branch_negative();
    test_misaligned();
    test_timeout();
    test_ack_last_cycle();
    test_halt_priority();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_instr_fetch_unit
